// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands and control at the end of ID,
// and drives the EX-stage forwarding selects from the registered source numbers.
module id_ex_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Stall,
  input  logic               Flush,
  input  logic [DATA_W-1:0]  IdRsData,
  input  logic [DATA_W-1:0]  IdRtData,
  input  logic [15:0]        IdImm16,
  input  logic               IdImmZeroExt,
  input  logic [REG_AW-1:0]  IdRs,
  input  logic [REG_AW-1:0]  IdRt,
  input  logic [REG_AW-1:0]  IdRd,
  input  logic [5:0]         IdCtrl,
  input  logic [ALUOP_W-1:0] IdALUOp,
  input  logic               WbRegWrite,
  input  logic [REG_AW-1:0]  WbRd,
  input  logic [DATA_W-1:0]  WbData,
  input  logic               ExMemRegWrite,
  input  logic [REG_AW-1:0]  ExMemRd,
  output logic [DATA_W-1:0]  ExRsData,
  output logic [DATA_W-1:0]  ExRtData,
  output logic [DATA_W-1:0]  ExImm,
  output logic [REG_AW-1:0]  ExRs,
  output logic [REG_AW-1:0]  ExRt,
  output logic [REG_AW-1:0]  ExRd,
  output logic [5:0]         ExCtrl,
  output logic [ALUOP_W-1:0] ExALUOp,
  output logic               ExALUSrc,
  output logic               ExValid,
  output logic [1:0]         FwdASel,
  output logic [1:0]         FwdBSel
);

  localparam logic [1:0] SEL_NONE  = 2'b00;
  localparam logic [1:0] SEL_MEMWB = 2'b01;
  localparam logic [1:0] SEL_EXMEM = 2'b10;

  // Upper bits beyond 32 are always zero, so wide datapaths see a 32-bit value.
  function automatic logic [DATA_W-1:0] extend_imm(input logic [15:0] imm,
                                                   input logic        zext);
    logic [DATA_W-1:0] r;
    r = '0;
    r[15:0] = imm;
    if (!zext && imm[15]) r[31:16] = 16'hFFFF;
    return r;
  endfunction

  // Register-file write happening this cycle wins over the stale read value.
  function automatic logic [DATA_W-1:0] wb_bypass(input logic [DATA_W-1:0] rf_data,
                                                  input logic [REG_AW-1:0] src);
    logic [DATA_W-1:0] r;
    r = rf_data;
    if (WbRegWrite && (WbRd != '0) && (WbRd == src)) r = WbData;
    return r;
  endfunction

  function automatic logic [1:0] fwd_sel(input logic              valid,
                                         input logic [REG_AW-1:0] src);
    logic [1:0] r;
    r = SEL_NONE;
    if (valid) begin
      if (ExMemRegWrite && (ExMemRd != '0) && (ExMemRd == src))
        r = SEL_EXMEM;
      else if (WbRegWrite && (WbRd != '0) && (WbRd == src))
        r = SEL_MEMWB;
    end
    return r;
  endfunction

  logic [DATA_W-1:0]  rs_data_q, rs_data_d;
  logic [DATA_W-1:0]  rt_data_q, rt_data_d;
  logic [DATA_W-1:0]  imm_q, imm_d;
  logic [REG_AW-1:0]  rs_q, rs_d;
  logic [REG_AW-1:0]  rt_q, rt_d;
  logic [REG_AW-1:0]  rd_q, rd_d;
  logic [5:0]         ctrl_q, ctrl_d;
  logic [ALUOP_W-1:0] aluop_q, aluop_d;
  logic               valid_q, valid_d;

  always_comb begin
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    ctrl_d    = ctrl_q;
    aluop_d   = aluop_q;
    valid_d   = valid_q;
    if (Flush) begin
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      rs_d      = '0;
      rt_d      = '0;
      rd_d      = '0;
      ctrl_d    = '0;
      aluop_d   = '0;
      valid_d   = 1'b0;
    end else if (!Stall) begin
      rs_data_d = wb_bypass(IdRsData, IdRs);
      rt_data_d = wb_bypass(IdRtData, IdRt);
      imm_d     = extend_imm(IdImm16, IdImmZeroExt);
      rs_d      = IdRs;
      rt_d      = IdRt;
      rd_d      = IdRd;
      ctrl_d    = IdCtrl;
      aluop_d   = IdALUOp;
      valid_d   = 1'b1;
    end
  end

  // ID -> EX boundary
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      ctrl_q    <= '0;
      aluop_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      ctrl_q    <= ctrl_d;
      aluop_q   <= aluop_d;
      valid_q   <= valid_d;
    end
  end

  assign ExRsData = rs_data_q;
  assign ExRtData = rt_data_q;
  assign ExImm    = imm_q;
  assign ExRs     = rs_q;
  assign ExRt     = rt_q;
  assign ExRd     = rd_q;
  assign ExCtrl   = ctrl_q;
  assign ExALUOp  = aluop_q;
  assign ExALUSrc = ctrl_q[0];
  assign ExValid  = valid_q;

  // Selects depend only on registered sources and live downstream state.
  assign FwdASel = fwd_sel(valid_q, rs_q);
  assign FwdBSel = fwd_sel(valid_q, rt_q);

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage datapath.
- Captures decoded operands, the extended immediate, register numbers and control bits at the end of ID.
- Generates the 2-bit forwarding selects and the ALUSrc bit consumed directly by the EX-stage 32-bit 4:1 operand muxes. Select encoding: 00 = register value or immediate, 01 = MEM/WB result, 10 = EX/MEM result.
- Supports stall (hold), flush (bubble insert) and write-back-to-read bypass at capture.

Parameters:
DATA_W, 32, operand/immediate width
REG_AW, 5, register-number width
ALUOP_W, 4, ALU operation code width

Ports:
Clk  input  1  pipeline clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Stall  input  1  hold current contents (from hazard unit)
Flush  input  1  load a bubble (branch taken / load-use)
IdRsData  input  DATA_W  register file read port A
IdRtData  input  DATA_W  register file read port B
IdImm16  input  16  raw instruction immediate
IdImmZeroExt  input  1  1 = zero-extend imm, 0 = sign-extend
IdRs, IdRt, IdRd  input  REG_AW each  source/dest register numbers
IdCtrl  input  6  {RegWrite, MemRead, MemWrite, MemToReg, RegDst, ALUSrc}
IdALUOp  input  ALUOP_W  ALU operation
WbRegWrite  input  1  WB stage writes register file this cycle
WbRd  input  REG_AW  WB destination
WbData  input  DATA_W  WB write data
ExMemRegWrite  input  1  EX/MEM instruction writes a register
ExMemRd  input  REG_AW  EX/MEM destination
ExRsData, ExRtData  output  DATA_W each  registered operands (mux in0 sources)
ExImm  output  DATA_W  registered extended immediate (mux in3 source)
ExRs, ExRt, ExRd  output  REG_AW each  registered register numbers
ExCtrl  output  6  registered control bits, same packing as IdCtrl
ExALUOp  output  ALUOP_W  registered ALU op
ExALUSrc  output  1  equals ExCtrl[0]; drives mux ALUscr
ExValid  output  1  1 = EX holds a real instruction
FwdASel, FwdBSel  output  2 each  forwarding selects for operand muxes A/B

Behaviour:
- Update priority each rising Clk edge: Reset > Flush > Stall > load.
- Reset: every registered output = 0, ExValid = 0, therefore FwdASel = FwdBSel = 00, ExALUSrc = 0. Reset mid-stall/flush simply clears.
- Flush (Flush=1, regardless of Stall): all registered fields cleared to 0, ExValid = 0. Result is a bubble with no writes and no memory access.
- Stall (Stall=1, Flush=0): every register holds; forwarding outputs continue to be recomputed from held ExRs/ExRt against live ExMem/Wb inputs.
- Load (neither): capture all ID inputs; ExValid <= 1. Latency ID -> EX outputs = 1 cycle.
- Immediate at capture:
  - IdImmZeroExt=1: ExImm = {16'b0, IdImm16}.
  - Otherwise: {16{IdImm16[15]}, IdImm16}.
  - Zero-extension of the upper bits applies for DATA_W>32.
- WB bypass at capture:
  - If WbRegWrite && WbRd!=0 && WbRd==IdRs, ExRsData <= WbData, else IdRsData.
  - Same rule independently for Rt.
  - Register 0 never bypassed.
- Forwarding selects, combinational from registered state, A shown (B identical using ExRt):
  - ExValid=0 -> 00.
  - Else ExMemRegWrite && ExMemRd!=0 && ExMemRd==ExRs -> 10.
  - Else WbRegWrite && WbRd!=0 && WbRd==ExRs -> 01.
  - Else 00.
  - EX/MEM has priority over MEM/WB when both match.
  - Select value 11 never produced.
- FwdBSel is generated even when ExALUSrc=1. The downstream mux ignores ALUSrc unless the select is 00.
- No internal combinational path from Id* inputs to any Ex* output.

Test Plan:
- Reset held 2 cycles with IdCtrl=6'h3F, IdRsData=32'hDEADBEEF -> all outputs 0, ExValid=0, FwdASel=00. Deassert -> next edge ExRsData=32'hDEADBEEF, ExValid=1.
- Load IdImm16=16'h8004, IdImmZeroExt=0 -> ExImm=32'hFFFF8004. Repeat with IdImmZeroExt=1 -> 32'h00008004.
- Forwarding with ExRs=5, ExRt=5:
  - ExMemRegWrite=1, ExMemRd=5, WbRegWrite=1, WbRd=5 -> FwdASel=FwdBSel=10.
  - Drop ExMemRegWrite -> 01.
  - ExMemRd=0 with ExRs=0 -> 00.
- Stall=1 for 3 cycles while Id* inputs change -> outputs unchanged. Stall=1 with Flush=1 -> bubble (ExCtrl=0, ExValid=0, FwdASel=00).
- WB bypass: IdRs=7, IdRsData=32'h1, WbRegWrite=1, WbRd=7, WbData=32'h55 -> ExRsData=32'h55. Same with WbRd=0 and IdRs=0 -> ExRsData=IdRsData.
- Back-to-back loads of 4 instructions, no stall -> each appears on Ex* exactly one cycle after presentation, in order.
